// File: rtl/plab4_net_router_input_ctrl_sep_if.sv
// Handshake and request bundle between one router input queue, its upstream
// sender and the three separate-wire output controllers.
interface plab4_net_router_input_ctrl_sep_if #(
   parameter int p_msg_nbits = 44
);
   logic                   in_val;
   logic                   in_rdy;
   logic [p_msg_nbits-1:0] in_msg;
   logic                   in_domain;

   logic                   reqs_p0;
   logic                   reqs_p1;
   logic                   reqs_p2;
   logic                   reqs_p0_domain;
   logic                   reqs_p1_domain;
   logic                   reqs_p2_domain;

   logic                   grants_p0;
   logic                   grants_p1;
   logic                   grants_p2;

   logic [p_msg_nbits-1:0] out_msg;
   logic                   out_domain;

   modport master (
      output in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
      input  in_rdy, reqs_p0, reqs_p1, reqs_p2,
             reqs_p0_domain, reqs_p1_domain, reqs_p2_domain,
             out_msg, out_domain
   );

   modport slave (
      input  in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
      output in_rdy, reqs_p0, reqs_p1, reqs_p2,
             reqs_p0_domain, reqs_p1_domain, reqs_p2_domain,
             out_msg, out_domain
   );
endinterface

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Ring-router input stage: circular message+domain queue, head route decode
// onto one of three separate request wires, dequeue on matching grant.
module plab4_net_router_input_ctrl_sep #(
   parameter int p_msg_nbits   = 44,
   parameter int p_dest_lsb    = 32,
   parameter int p_dest_nbits  = 2,
   parameter int p_num_routers = 4,
   parameter int p_router_id   = 0,
   parameter int p_num_entries = 4
) (
   input logic clk,
   input logic reset,
   plab4_net_router_input_ctrl_sep_if.slave ifc
);
   localparam int c_ptr_bits = $clog2(p_num_entries);
   localparam int c_cnt_bits = c_ptr_bits + 1;
   localparam int c_rt_bits  = $clog2(p_num_routers);

   localparam logic [c_cnt_bits-1:0] c_full = c_cnt_bits'(p_num_entries);
   localparam logic [c_cnt_bits-1:0] c_zero = {c_cnt_bits{1'b0}};
   localparam logic [c_rt_bits-1:0]  c_id   = c_rt_bits'(p_router_id);
   localparam logic [c_rt_bits:0]    c_half = (c_rt_bits + 1)'(p_num_routers / 2);

   // Low c_rt_bits of the dest field are the destination modulo the ring size,
   // so the subtraction wraps naturally; a forward distance of exactly half goes east.
   function automatic logic [2:0] route_fn(input logic [p_msg_nbits-1:0] msg);
      logic [c_rt_bits-1:0] fwd;
      fwd = msg[p_dest_lsb +: c_rt_bits] - c_id;
      if (fwd == {c_rt_bits{1'b0}}) begin
         route_fn = 3'b010;
      end else if ({1'b0, fwd} <= c_half) begin
         route_fn = 3'b100;
      end else begin
         route_fn = 3'b001;
      end
   endfunction

   logic [p_msg_nbits:0]  slots_r [p_num_entries];
   logic [c_ptr_bits-1:0] head_r;
   logic [c_ptr_bits-1:0] tail_r;
   logic [c_cnt_bits-1:0] count_r;

   logic                  valid_s;
   logic                  in_rdy_s;
   logic                  enq_s;
   logic                  deq_s;
   logic [p_msg_nbits:0]  head_slot_s;
   logic [2:0]            reqs_s;
   logic [2:0]            grants_s;

   assign grants_s = {ifc.grants_p2, ifc.grants_p1, ifc.grants_p0};

   // Head decode; everything is zeroed when empty or in reset so no stale data leaks.
   always_comb begin
      valid_s     = reset && (count_r != c_zero);
      in_rdy_s    = reset && (count_r != c_full);
      head_slot_s = {(p_msg_nbits + 1){1'b0}};
      reqs_s      = 3'b000;
      if (valid_s) begin
         head_slot_s = slots_r[head_r];
         reqs_s      = route_fn(head_slot_s[p_msg_nbits-1:0]);
      end else begin
         head_slot_s = {(p_msg_nbits + 1){1'b0}};
         reqs_s      = 3'b000;
      end
      enq_s = ifc.in_val && in_rdy_s;
      deq_s = |(reqs_s & grants_s);
   end

   assign ifc.in_rdy         = in_rdy_s;
   assign ifc.reqs_p0        = reqs_s[0];
   assign ifc.reqs_p1        = reqs_s[1];
   assign ifc.reqs_p2        = reqs_s[2];
   assign ifc.out_msg        = head_slot_s[p_msg_nbits-1:0];
   assign ifc.out_domain     = head_slot_s[p_msg_nbits];
   assign ifc.reqs_p0_domain = head_slot_s[p_msg_nbits];
   assign ifc.reqs_p1_domain = head_slot_s[p_msg_nbits];
   assign ifc.reqs_p2_domain = head_slot_s[p_msg_nbits];

   // Queue pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head_r  <= {c_ptr_bits{1'b0}};
         tail_r  <= {c_ptr_bits{1'b0}};
         count_r <= c_zero;
      end else begin
         if (enq_s) tail_r <= tail_r + c_ptr_bits'(1);
         else       tail_r <= tail_r;
         if (deq_s) head_r <= head_r + c_ptr_bits'(1);
         else       head_r <= head_r;
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + c_cnt_bits'(1);
            2'b01:   count_r <= count_r - c_cnt_bits'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Slot storage; contents are only observable while counted as valid.
   always_ff @(posedge clk) begin
      if (enq_s) slots_r[tail_r] <= {ifc.in_domain, ifc.in_msg};
   end
endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
// Bench for the ring-router input stage: routing table, directed corner
// sequences and random traffic checked against a queue-based reference model.
module tb_plab4_net_router_input_ctrl_sep;
   localparam int c_nbits = 44;
   localparam int c_lsb   = 32;
   localparam int c_dbits = 2;
   localparam int c_nr    = 4;
   localparam int c_id    = 1;
   localparam int c_ne    = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   plab4_net_router_input_ctrl_sep_if #(.p_msg_nbits(c_nbits)) bus ();

   plab4_net_router_input_ctrl_sep #(
      .p_msg_nbits(c_nbits), .p_dest_lsb(c_lsb), .p_dest_nbits(c_dbits),
      .p_num_routers(c_nr), .p_router_id(c_id), .p_num_entries(c_ne)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ifc(bus)
   );

   logic [c_nbits:0] q[$];
   int checks = 0;
   int errors = 0;

   // Expected one-hot {p2,p1,p0} from the ring distance rule.
   function automatic logic [2:0] route_of(logic [c_nbits-1:0] m);
      int dest;
      int fwd;
      dest = int'(m[c_lsb +: c_dbits]);
      fwd  = (((dest - c_id) % c_nr) + c_nr) % c_nr;
      if (fwd == 0)            return 3'b010;
      else if (fwd <= c_nr / 2) return 3'b100;
      else                     return 3'b001;
   endfunction

   function automatic logic [c_nbits-1:0] mk_msg(int dest);
      logic [63:0] r;
      logic [c_nbits-1:0] m;
      r = {$urandom(), $urandom()};
      m = r[c_nbits-1:0];
      m[c_lsb +: c_dbits] = c_dbits'(dest);
      return m;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] reqs_now();
      return {bus.reqs_p2, bus.reqs_p1, bus.reqs_p0};
   endfunction

   task automatic check_model();
      logic [2:0] er;
      logic ed;
      logic erdy;
      logic [c_nbits-1:0] em;
      erdy = reset && (q.size() != c_ne);
      if (reset && q.size() != 0) begin
         em = q[0][c_nbits-1:0];
         ed = q[0][c_nbits];
         er = route_of(em);
      end else begin
         em = '0;
         ed = 1'b0;
         er = 3'b000;
      end
      chk("in_rdy", 64'(bus.in_rdy), 64'(erdy));
      chk("reqs", 64'(reqs_now()), 64'(er));
      chk("req_domains", 64'({bus.reqs_p2_domain, bus.reqs_p1_domain, bus.reqs_p0_domain}),
          64'({ed, ed, ed}));
      chk("out_msg", 64'(bus.out_msg), 64'(em));
      chk("out_domain", 64'(bus.out_domain), 64'(ed));
   endtask

   // Apply inputs for one cycle, check current outputs, advance model at the edge.
   task automatic step(logic val, logic [c_nbits-1:0] msg, logic dom, logic [2:0] gnt);
      logic enq;
      logic deq;
      bus.in_val    = val;
      bus.in_msg    = msg;
      bus.in_domain = dom;
      bus.grants_p0 = gnt[0];
      bus.grants_p1 = gnt[1];
      bus.grants_p2 = gnt[2];
      #1;
      check_model();
      enq = reset && val && (q.size() != c_ne);
      deq = reset && (q.size() != 0) && ((gnt & route_of(q[0][c_nbits-1:0])) != 3'b000);
      @(posedge clk);
      if (!reset) begin
         q.delete();
      end else begin
         if (deq) void'(q.pop_front());
         if (enq) q.push_back({dom, msg});
      end
      #1;
   endtask

   typedef struct {
      int         dest;
      logic       dom;
      logic [2:0] exp_reqs;
   } route_vec_t;

   route_vec_t tbl[4];
   logic [c_nbits-1:0] seq[8];
   logic [c_nbits-1:0] ma, mb, mc;
   logic [2:0] r3;

   initial begin
      tbl[0] = '{dest: 1, dom: 1'b0, exp_reqs: 3'b010};
      tbl[1] = '{dest: 2, dom: 1'b1, exp_reqs: 3'b100};
      tbl[2] = '{dest: 3, dom: 1'b0, exp_reqs: 3'b100};
      tbl[3] = '{dest: 0, dom: 1'b1, exp_reqs: 3'b001};

      reset = 1'b0;
      bus.in_val = 1'b0; bus.in_msg = '0; bus.in_domain = 1'b0;
      bus.grants_p0 = 1'b0; bus.grants_p1 = 1'b0; bus.grants_p2 = 1'b0;

      // Reset held with traffic offered
      step(1'b1, mk_msg(1), 1'b1, 3'b000);
      step(1'b1, mk_msg(2), 1'b1, 3'b111);
      chk("rst_in_rdy", 64'(bus.in_rdy), 64'(1'b0));
      reset = 1'b1;
      #1;
      chk("rel_in_rdy", 64'(bus.in_rdy), 64'(1'b1));
      chk("rel_empty_reqs", 64'(reqs_now()), 64'(3'b000));

      // Routing table
      for (int i = 0; i < 4; i++) begin
         ma = mk_msg(tbl[i].dest);
         step(1'b1, ma, tbl[i].dom, 3'b000);
         chk($sformatf("route_d%0d", tbl[i].dest), 64'(reqs_now()), 64'(tbl[i].exp_reqs));
         chk($sformatf("route_dom%0d", tbl[i].dest), 64'(bus.out_domain), 64'(tbl[i].dom));
         step(1'b0, '0, 1'b0, ~tbl[i].exp_reqs);
         chk($sformatf("route_hold%0d", tbl[i].dest), 64'(reqs_now()), 64'(tbl[i].exp_reqs));
         step(1'b0, '0, 1'b0, tbl[i].exp_reqs);
         chk($sformatf("route_drained%0d", tbl[i].dest), 64'(reqs_now()), 64'(3'b000));
      end

      // Fill, back-pressure, single grant, then drain with pointer wrap
      for (int i = 0; i < 8; i++) seq[i] = mk_msg(i % 4);
      for (int i = 0; i < 4; i++) step(1'b1, seq[i], i[0], 3'b000);
      chk("full_in_rdy", 64'(bus.in_rdy), 64'(1'b0));
      step(1'b1, seq[7], 1'b0, 3'b000);
      chk("full_head", 64'(bus.out_msg), 64'(seq[0]));
      step(1'b1, seq[7], 1'b0, 3'b111);
      chk("regrant_in_rdy", 64'(bus.in_rdy), 64'(1'b1));
      chk("after_grant_head", 64'(bus.out_msg), 64'(seq[1]));
      step(1'b1, seq[4], 1'b0, 3'b000);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("drain%0d", i), 64'(bus.out_msg), 64'(seq[i]));
         step(1'b0, '0, 1'b0, 3'b111);
      end
      step(1'b1, seq[5], 1'b1, 3'b000);
      step(1'b1, seq[6], 1'b0, 3'b000);
      chk("wrap_head5", 64'(bus.out_msg), 64'(seq[5]));
      step(1'b0, '0, 1'b0, 3'b111);
      chk("wrap_head6", 64'(bus.out_msg), 64'(seq[6]));
      step(1'b0, '0, 1'b0, 3'b111);

      // Simultaneous enqueue and dequeue at two entries
      ma = mk_msg(2); mb = mk_msg(0); mc = mk_msg(1);
      step(1'b1, ma, 1'b0, 3'b000);
      step(1'b1, mb, 1'b0, 3'b000);
      step(1'b1, mc, 1'b1, route_of(ma));
      chk("simul_head", 64'(bus.out_msg), 64'(mb));
      step(1'b0, '0, 1'b0, route_of(mb));
      chk("simul_next", 64'(bus.out_msg), 64'(mc));
      step(1'b0, '0, 1'b0, route_of(mc));
      chk("simul_empty", 64'(bus.in_rdy), 64'(1'b1));

      // Domain tracking and spurious grant
      ma = mk_msg(3); mb = mk_msg(1);
      step(1'b1, ma, 1'b1, 3'b000);
      step(1'b1, mb, 1'b0, 3'b000);
      chk("domA_out", 64'(bus.out_domain), 64'(1'b1));
      chk("domA_req", 64'(bus.reqs_p2_domain), 64'(1'b1));
      r3 = ~route_of(ma);
      step(1'b0, '0, 1'b0, r3);
      chk("spurious_head", 64'(bus.out_msg), 64'(ma));
      step(1'b0, '0, 1'b0, route_of(ma));
      chk("domB_out", 64'(bus.out_domain), 64'(1'b0));
      chk("domB_msg", 64'(bus.out_msg), 64'(mb));
      step(1'b0, '0, 1'b0, route_of(mb));
      chk("empty_msg", 64'(bus.out_msg), 64'(0));
      chk("empty_dom", 64'(bus.out_domain), 64'(1'b0));

      // Reset mid-operation discards contents
      step(1'b1, mk_msg(2), 1'b1, 3'b000);
      step(1'b1, mk_msg(0), 1'b1, 3'b000);
      reset = 1'b0;
      step(1'b0, '0, 1'b0, 3'b000);
      reset = 1'b1;
      #1;
      chk("midrst_reqs", 64'(reqs_now()), 64'(3'b000));
      chk("midrst_msg", 64'(bus.out_msg), 64'(0));

      // Random traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 59) != 0);
         step(($urandom_range(0, 2) != 0), mk_msg(int'($urandom_range(0, 3))),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      reset = 1'b1;
      step(1'b0, '0, 1'b0, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/plab4_net_router_input_ctrl_sep.md
Name: plab4_net_router_input_ctrl_sep

Overview:
- Per-input-port stage of the ring router. Sits directly upstream of the three separate-wire output controllers (p0 = west/prev, p1 = terminal, p2 = east/next).
- Buffers incoming messages together with their security-domain bit in a small circular queue.
- Computes the route of the head message and raises exactly one separate request wire, tagged with the head's domain.
- Dequeues the head when the matching output controller returns a grant.

Parameters:
- p_msg_nbits, 44, width of the network message.
- p_dest_lsb, 32, bit index of the destination field's LSB within the message.
- p_dest_nbits, 2, width of the destination field.
- p_num_routers, 4, routers in the ring; power of two, at most 2^p_dest_nbits.
- p_router_id, 0, id of this router.
- p_num_entries, 4, queue depth; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; reset asserted when reset==0, sampled on posedge clk.
- in_val  input  1  upstream message valid.
- in_rdy  output  1  queue can accept a message.
- in_msg  input  p_msg_nbits  upstream message.
- in_domain  input  1  security domain of in_msg (0 = low, 1 = high).
- reqs_p0  output  1  head requests west/prev output.
- reqs_p1  output  1  head requests terminal output.
- reqs_p2  output  1  head requests east/next output.
- reqs_p0_domain  output  1  domain of the head; driven identically on all three domain outputs.
- reqs_p1_domain  output  1  same value as reqs_p0_domain.
- reqs_p2_domain  output  1  same value as reqs_p0_domain.
- grants_p0  input  1  grant from west/prev output controller.
- grants_p1  input  1  grant from terminal output controller.
- grants_p2  input  1  grant from east/next output controller.
- out_msg  output  p_msg_nbits  head message, to the crossbar.
- out_domain  output  1  domain of the head message.

Behaviour:
- Storage: p_num_entries message+domain slots; head pointer, tail pointer, count register (log2(p_num_entries)+1 bits). Pointers wrap modulo p_num_entries.
- Reset (reset==0 at posedge):
  - head=tail=count=0.
  - in_rdy forced 0 while reset==0.
  - All reqs_pX=0; all domain outputs=0; out_msg=0; out_domain=0.
- in_rdy = reset && (count != p_num_entries). Combinational from registered count only; no dependence on grants.
- Enqueue when in_val && in_rdy: slot[tail] <= {in_domain, in_msg}; tail++.
- Latency: an enqueued message appears at the head, with requests, the cycle after acceptance. There is no same-cycle bypass.
- Route computation, all arithmetic modulo p_num_routers:
  - fwd = (dest - p_router_id).
  - fwd==0 -> p1.
  - 0 < fwd <= p_num_routers/2 -> p2; the tie at exactly half goes east.
  - Otherwise -> p0.
- Requests: when count != 0, exactly one of reqs_p0..p2 is 1, selected by the route; all others are 0. When count==0, all are 0.
- Domain outputs: when count != 0, out_msg/out_domain/reqs_pX_domain = head slot. When count==0, all are 0, so no stale high data leaks.
- Dequeue when (reqs_pX && grants_pX) for the requested X: head++.
  - A grant on a non-requested port is ignored: no dequeue, no state change.
  - Multiple grants in one cycle still dequeue at most once.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue.
- Full queue with a grant: in_rdy is already 0, so no enqueue that cycle. count becomes p_num_entries-1 and in_rdy rises the next cycle.
- Empty queue with in_val: enqueue; no request this cycle.
- Requests are held stable with an unchanged head until granted. Round-robin fairness is the downstream arbiter's job.
- Reset mid-operation: all queued messages are discarded; state and outputs return to reset values on that edge.
- Message contents are never modified. Domain bits travel with their message through the queue.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_val=1 -> in_rdy=0, all reqs_pX=0, count stays 0. Release -> in_rdy=1 next cycle.
- Routing with p_router_id=1, p_num_routers=4:
  - dest=1 -> reqs_p1.
  - dest=2 -> reqs_p2.
  - dest=3 -> reqs_p2 (tie, fwd=2).
  - dest=0 -> reqs_p0.
  - Each request appears exactly 1 cycle after acceptance and is held until grants_pX=1.
- Full/back-pressure:
  - Enqueue 4 messages with no grants -> in_rdy=0 after the 4th; a 5th in_val is not accepted.
  - Grant once -> in_rdy=1 the next cycle.
  - Drain order matches enqueue order (pointer wrap checked after 6+ messages).
- Simultaneous enq/deq at count=2: in_val=1 and a matching grant -> count stays 2, and the next head is the second-oldest message.
- Domain and spurious grant:
  - Enqueue msg A (domain 1) then B (domain 0) -> out_domain=1 and reqs_pX_domain=1 while A heads; 0 after A is granted.
  - A grant on a non-requested port causes no dequeue.
  - With the queue empty, out_msg=0 and out_domain=0.
